// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with an internal flag register.
// Single-cycle ops complete at the accept edge. MUL is an iterative
// shift-add multiply that takes WIDTH steps.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flags_wr,
  input  logic [4:0]       flags_din,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE     = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_hi, mplr, mcand;
  logic [CW-1:0]    count;
  logic             last;

  // single-cycle ALU signals
  logic             cin;
  logic [WIDTH:0]   ea, eb, cin_w, wide;
  logic [WIDTH-1:0] alu_res;
  logic             c_n, ov_n, z_n, s_n, p_n, upd;
  logic [4:0]       alu_flags;

  // multiply step signals
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [4:0]       mul_flags;

  assign cin   = flags[2];
  assign ea    = {1'b0, a};
  assign eb    = {1'b0, b};
  assign cin_w = {{WIDTH{1'b0}}, cin};
  assign ready = (state == IDLE);
  assign last  = (count == CW'(WIDTH - 1));

  // One shift-add step: add multiplicand when the multiplier LSB is set,
  // then shift the {carry, acc_hi, mplr} chain right by one.
  assign step_sum  = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : '0);
  assign step_hi   = step_sum[WIDTH:1];
  assign step_lo   = {step_sum[0], mplr[WIDTH-1:1]};
  assign mul_flags = {(step_hi != '0), ~^step_lo, (step_hi != '0),
                      step_hi[WIDTH-1], ({step_hi, step_lo} == '0)};

  // Single-cycle op result and next flags; Z/S/P only refresh when upd is set.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    c_n     = cin;
    ov_n    = flags[4];
    upd     = 1'b0;
    case (op)
      4'h0, 4'h1: begin
        wide    = ea + eb + ((op == 4'h1) ? cin_w : '0);
        alu_res = wide[WIDTH-1:0];
        c_n     = wide[WIDTH];
        ov_n    = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
        upd     = 1'b1;
      end
      4'h2, 4'h3, 4'h7: begin
        wide    = ea - eb - ((op == 4'h3) ? cin_w : '0);
        alu_res = wide[WIDTH-1:0];
        c_n     = wide[WIDTH];
        ov_n    = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
        upd     = 1'b1;
      end
      4'h4: begin alu_res = a & b; c_n = 1'b0; ov_n = 1'b0; upd = 1'b1; end
      4'h5: begin alu_res = a | b; c_n = 1'b0; ov_n = 1'b0; upd = 1'b1; end
      4'h6: begin alu_res = a ^ b; c_n = 1'b0; ov_n = 1'b0; upd = 1'b1; end
      4'h8: begin
        wide    = ea + ONE;
        alu_res = wide[WIDTH-1:0];
        ov_n    = (a == MAX_POS);
        upd     = 1'b1;
      end
      4'h9: begin
        wide    = ea - ONE;
        alu_res = wide[WIDTH-1:0];
        ov_n    = (a == MIN_NEG);
        upd     = 1'b1;
      end
      4'hA: begin alu_res = {a[WIDTH-2:0], cin}; c_n = a[WIDTH-1]; ov_n = 1'b0; upd = 1'b1; end
      4'hB: begin alu_res = {cin, a[WIDTH-1:1]}; c_n = a[0];       ov_n = 1'b0; upd = 1'b1; end
      4'hD: c_n = 1'b1;
      4'hE: c_n = ~cin;
      default: ;
    endcase
    z_n = upd ? (alu_res == '0)      : flags[0];
    s_n = upd ? alu_res[WIDTH-1]     : flags[1];
    p_n = upd ? ~^alu_res            : flags[3];
    alu_flags = {ov_n, p_n, c_n, s_n, z_n};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: enter MUL on an accepted MUL, leave after the last step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && op == 4'hC) state_nxt = MUL;
      MUL:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: results, flags, done pulse and the multiply registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
      acc_hi    <= '0;
      mplr      <= '0;
      mcand     <= '0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == 4'hC) begin
              acc_hi <= '0;
              mplr   <= b;
              mcand  <= a;
              count  <= '0;
            end else begin
              done  <= 1'b1;
              flags <= alu_flags;
              // CMP only touches flags
              if (op != 4'h7) begin
                result_lo <= alu_res;
                result_hi <= '0;
              end
            end
          end else if (flags_wr) begin
            flags <= flags_din;
          end
        end
        MUL: begin
          acc_hi <= step_hi;
          mplr   <= step_lo;
          count  <= count + 1'b1;
          if (last) begin
            result_hi <= step_hi;
            result_lo <= step_lo;
            flags     <= mul_flags;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit combinational ALU, and the execute-stage arithmetic unit of the Dyna-85 datapath. It owns an internal flag register that supplies carry to ADC/SBB/RLC/RRC. It adds signed overflow, rotate-right, carry set/complement, and an iterative unsigned multiply. A start/ready/done handshake lets the control FSM issue one single-cycle op per clock and stall only on MUL.

## Interface
- WIDTH, 8, operand/result width; legal range 4..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on an edge where start=1 and ready=1.
- op  in  4  opcode, sampled at accept.
- a, b  in  WIDTH  operands, sampled at accept.
- flags_wr  in  1  load flag register from flags_din (PSW restore).
- flags_din  in  5  value for flags_wr.
- ready  out  1  =1 in IDLE (combinational from state).
- done  out  1  registered one-cycle pulse marking an op result.
- result_lo  out  WIDTH  registered result (product low half for MUL).
- result_hi  out  WIDTH  product high half for MUL, 0 for all other ops.
- flags  out  5  flag register: bit0 Z, bit1 S, bit2 C, bit3 P, bit4 OV.

## Operation
- Opcodes:
  - 0 ADD; 1 ADC (a+b+C); 2 SUB; 3 SBB (a-b-C); 4 AND; 5 OR; 6 XOR.
  - 7 CMP: flags from a-b; result_lo/result_hi hold their previous values.
  - 8 INR a+1; 9 DCR a-1.
  - A RLC: {a[W-2:0],C}, new C=a[W-1]. B RRC: {C,a[W-1:1]}, new C=a[0].
  - C MUL: unsigned a*b, 2*WIDTH bits.
  - D STC: C=1. E CMC: C=~C. D/E produce result 0 and leave other flags unchanged.
  - F NOP: result 0, flags unchanged.
- Arithmetic is computed at WIDTH+1 bits.
  - C is carry-out for add ops and borrow (a < b+cin, unsigned) for sub ops.
  - AND/OR/XOR clear C and OV.
  - INR/DCR leave C unchanged.
- Z/S/P are updated for ops 0-C:
  - Z = (result == 0). For MUL, Z covers the full 2*WIDTH product.
  - S = MSB of the result (product bit 2W-1 for MUL).
  - P = 1 when result_lo has an even number of ones.
- OV (signed overflow):
  - ADD/ADC: operands have equal MSBs and the result MSB differs.
  - SUB/SBB/CMP: operand MSBs differ and the result MSB differs from a's MSB.
  - INR: a = 0111..1. DCR: a = 1000..0.
  - RLC/RRC clear OV. For MUL, C = OV = (result_hi != 0).
- FSM has two states:
  - IDLE: accepting non-MUL updates result/flags at the accept edge and stays in IDLE. Accepting MUL clears the accumulator, loads a/b, sets count=0, and moves to MUL.
  - MUL: one shift-add step per clock for WIDTH cycles. The final step writes result_hi/lo and flags, then returns to IDLE.
- In MUL, start is ignored (no queuing) and flags_wr is ignored.
- flags_wr in IDLE: if start is also accepted on that edge, start wins and the flags_wr is dropped. Otherwise flags := flags_din and done is not pulsed.

## Timing
- Reset values: state IDLE, ready=1, done=0, result_lo=0, result_hi=0, flags=0.
- Single-cycle ops: result/flags are visible and done=1 in the cycle after the accept edge.
- Back-to-back accepts every cycle are legal; done stays high continuously.
- MUL: ready=0 for WIDTH cycles after the accept edge. done=1 in cycle WIDTH+1 after accept, and ready=1 in that same cycle.
- Outputs hold between ops; done is low otherwise.
- rst_n low mid-MUL aborts the operation immediately: no done, all outputs return to reset values.
- a/b/op changes after accept have no effect on an op in flight.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01 -> result_lo=0x00, Z=1 C=1 P=1 S=0 OV=0, done one cycle after accept.
- SUB 0x10-0x20 -> 0xF0, C=1 S=1 P=1 OV=0. Then ADC 0x01+0x01 -> 0x03, C=0.
- INR 0x7F with C=1 -> 0x80, OV=1 S=1, C still 1. Then RLC 0x81 with C=1 -> 0x03, C=1, OV=0.
- MUL 0x0F*0x11 -> hi=0x00 lo=0xFF, C=0. Also MUL 0xFF*0xFF -> hi=0xFE lo=0x01, C=OV=1. ready low for 8 cycles, done 9 cycles after accept, start pulses during busy ignored.
- flags_wr=1 with flags_din=0x1F in IDLE -> flags=0x1F, no done. Same write asserted together with an accepted start -> flags_din dropped.
- Assert rst_n low 4 cycles into a MUL -> outputs at reset values, no done. Next op executes normally.
